// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing constants and the shared coordinate type.
// The drawing stages use coord_t when they decode the xCount/yCount outputs.
package vga_timing_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam bit DEF_SYNC_POL  = 1'b0;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    localparam int DEF_CNT_W = 10;

    typedef logic [DEF_CNT_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one raster axis (0..TOTAL-1).
// Reset parks the counter on its last value, so the first increment lands on 0.
// count_next is exposed so that downstream registers can decode the position
// the counter is about to take, which keeps them aligned with count.
module vga_axis_counter #(
    parameter int TOTAL = 800,
    parameter int CNT_W = 10
) (
    input  logic             VGA_clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    assign wrap = inc && (count == LAST);

    // Next position: hold, step by one, or wrap back to zero.
    always_comb begin
        count_next = count;
        if (inc) begin
            count_next = wrap ? '0 : count + 1'b1;
        end
    end

    // Position register, parked on LAST while in reset.
    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            count <= LAST;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator. It produces the pixel position and the sync, display and strobe
// flags for that position. Every flag is registered from the decode of the next
// position, so each one always describes the pixel at (xCount, yCount).
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit SYNC_POL  = DEF_SYNC_POL,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             VGA_clk,
    input  logic             reset,
    input  logic             pix_en,
    output logic [CNT_W-1:0] xCount,
    output logic [CNT_W-1:0] yCount,
    output logic             displayArea,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start,
    output logic [7:0]       frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] H_SS_C   = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] H_SE_C   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_SS_C   = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] V_SE_C   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CNT_W-1:0] x_next;
    logic [CNT_W-1:0] y_next;
    logic             h_wrap;
    logic             v_wrap;
    logic             disp_next;
    logic             hsync_next;
    logic             vsync_next;
    logic             first_frame_seen;

    vga_axis_counter #(
        .TOTAL (H_TOTAL),
        .CNT_W (CNT_W)
    ) u_h_cnt (
        .VGA_clk    (VGA_clk),
        .reset      (reset),
        .inc        (pix_en),
        .count      (xCount),
        .count_next (x_next),
        .wrap       (h_wrap)
    );

    // The vertical axis steps only when the horizontal axis wraps.
    vga_axis_counter #(
        .TOTAL (V_TOTAL),
        .CNT_W (CNT_W)
    ) u_v_cnt (
        .VGA_clk    (VGA_clk),
        .reset      (reset),
        .inc        (h_wrap),
        .count      (yCount),
        .count_next (y_next),
        .wrap       (v_wrap)
    );

    // Decode of the position that takes effect on the coming edge.
    always_comb begin
        disp_next  = (x_next < H_VIS_C) && (y_next < V_VIS_C);
        hsync_next = ((x_next >= H_SS_C) && (x_next < H_SE_C)) ? SYNC_POL : ~SYNC_POL;
        vsync_next = ((y_next >= V_SS_C) && (y_next < V_SE_C)) ? SYNC_POL : ~SYNC_POL;
    end

    // Flag registers advance together with the counters and hold while pix_en is low.
    // h_wrap/v_wrap already imply pix_en, and they mean that the next position has x==0 or is (0,0).
    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            displayArea <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            displayArea <= disp_next;
            hsync       <= hsync_next;
            vsync       <= vsync_next;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end
    end

    // Frame counter. The first frame after reset is frame 0, and later frame starts increment the counter.
    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            frame_count      <= 8'd0;
            first_frame_seen <= 1'b0;
        end else if (v_wrap) begin
            first_frame_seen <= 1'b1;
            if (first_frame_seen) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. It drives a default-timing instance and a small-timing instance side by side.
// Each drive step pushes the expected outputs of a behavioural raster model to a queue.
// After the clock edge, the bench pops that entry and compares it with the DUT outputs.
module tb_vga_sync_gen;

    typedef struct { int hv, hf, hs, hb, vv, vf, vs, vb; bit pol; } tim_t;
    typedef struct { int x, y, fc; bit started; } mst_t;
    typedef struct { int x, y, fc; bit disp, hs, vs, ls, fs; } exp_t;

    logic clk;
    logic rst;
    logic pe;

    logic [9:0] d_x, d_y;
    logic       d_disp, d_hs, d_vs, d_ls, d_fs;
    logic [7:0] d_fc;
    logic [3:0] s_x, s_y;
    logic       s_disp, s_hs, s_vs, s_ls, s_fs;
    logic [7:0] s_fc;

    int   n_tests = 0;
    int   n_fail  = 0;
    tim_t td, ts;
    mst_t md, ms;
    exp_t qd[$];
    exp_t qs[$];

    vga_sync_gen dut_d (
        .VGA_clk(clk), .reset(rst), .pix_en(pe),
        .xCount(d_x), .yCount(d_y), .displayArea(d_disp),
        .hsync(d_hs), .vsync(d_vs), .line_start(d_ls),
        .frame_start(d_fs), .frame_count(d_fc)
    );

    vga_sync_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1'b1), .CNT_W(4)
    ) dut_s (
        .VGA_clk(clk), .reset(rst), .pix_en(pe),
        .xCount(s_x), .yCount(s_y), .displayArea(s_disp),
        .hsync(s_hs), .vsync(s_vs), .line_start(s_ls),
        .frame_start(s_fs), .frame_count(s_fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mst_t m_reset(tim_t t);
        mst_t m;
        m.x = t.hv + t.hf + t.hs + t.hb - 1;
        m.y = t.vv + t.vf + t.vs + t.vb - 1;
        m.fc = 0;
        m.started = 1'b0;
        return m;
    endfunction

    function automatic mst_t m_adv(mst_t m, tim_t t);
        mst_t r = m;
        int ht = t.hv + t.hf + t.hs + t.hb;
        int vt = t.vv + t.vf + t.vs + t.vb;
        if (r.x == ht - 1) begin
            r.x = 0;
            r.y = (r.y == vt - 1) ? 0 : r.y + 1;
        end else begin
            r.x = r.x + 1;
        end
        if (r.x == 0 && r.y == 0) begin
            if (r.started) r.fc = (r.fc + 1) % 256;
            r.started = 1'b1;
        end
        return r;
    endfunction

    function automatic exp_t m_exp(mst_t m, tim_t t);
        exp_t e;
        e.x    = m.x;
        e.y    = m.y;
        e.fc   = m.fc;
        e.disp = (m.x < t.hv) && (m.y < t.vv);
        e.hs   = (m.x >= t.hv + t.hf && m.x < t.hv + t.hf + t.hs) ? t.pol : !t.pol;
        e.vs   = (m.y >= t.vv + t.vf && m.y < t.vv + t.vf + t.vs) ? t.pol : !t.pol;
        e.ls   = (m.x == 0);
        e.fs   = (m.x == 0) && (m.y == 0);
        return e;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        exp_t ed, es;
        ed = qd.pop_front();
        es = qs.pop_front();
        cmp("D_x", 32'(d_x), 32'(ed.x));
        cmp("D_y", 32'(d_y), 32'(ed.y));
        cmp("D_disp", 32'(d_disp), 32'(ed.disp));
        cmp("D_hsync", 32'(d_hs), 32'(ed.hs));
        cmp("D_vsync", 32'(d_vs), 32'(ed.vs));
        cmp("D_line_start", 32'(d_ls), 32'(ed.ls));
        cmp("D_frame_start", 32'(d_fs), 32'(ed.fs));
        cmp("D_frame_count", 32'(d_fc), 32'(ed.fc));
        cmp("S_x", 32'(s_x), 32'(es.x));
        cmp("S_y", 32'(s_y), 32'(es.y));
        cmp("S_disp", 32'(s_disp), 32'(es.disp));
        cmp("S_hsync", 32'(s_hs), 32'(es.hs));
        cmp("S_vsync", 32'(s_vs), 32'(es.vs));
        cmp("S_line_start", 32'(s_ls), 32'(es.ls));
        cmp("S_frame_start", 32'(s_fs), 32'(es.fs));
        cmp("S_frame_count", 32'(s_fc), 32'(es.fc));
    endtask

    // Drive pix_en for one clock, push the model's expectation, then compare after the edge.
    task automatic cyc(input bit p);
        pe = p;
        if (rst) begin
            md = m_reset(td);
            ms = m_reset(ts);
        end else if (p) begin
            md = m_adv(md, td);
            ms = m_adv(ms, ts);
        end
        qd.push_back(m_exp(md, td));
        qs.push_back(m_exp(ms, ts));
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        logic p_hs, p_disp, p_ls, p_sfs;
        int   first_fs, ls_run, guard, vs_cnt;

        td = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
        ts = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b1};
        rst = 1'b1;
        pe  = 1'b1;
        md  = m_reset(td);
        ms  = m_reset(ts);

        // Hold reset for 5 clocks with pix_en high. The DUTs stay parked at the last position.
        repeat (5) cyc(1'b1);
        rst = 1'b0;

        // Default timing over two lines: hsync, displayArea and line_start edges.
        p_hs = 1'b1; p_disp = 1'b0; p_ls = 1'b0;
        for (int k = 0; k < 1700; k++) begin
            cyc(1'b1);
            if (p_hs && !d_hs)    cmp("D_hs_fall_x", 32'(d_x), 32'd656);
            if (!p_hs && d_hs)    cmp("D_hs_rise_x", 32'(d_x), 32'd752);
            if (p_disp && !d_disp) cmp("D_disp_drop_x", 32'(d_x), 32'd640);
            if (p_ls)             cmp("D_ls_one_clock", 32'(d_ls), 32'd0);
            p_hs = d_hs; p_disp = d_disp; p_ls = d_ls;
        end

        // Half-rate pixel enable: small frame takes 196 clocks, line_start lasts 2 clocks.
        first_fs = -1; ls_run = 0; p_sfs = s_fs;
        for (int k = 0; k < 500; k++) begin
            cyc(k % 2 == 0);
            if (s_fs && !p_sfs) begin
                if (first_fs >= 0) cmp("S_frame_clocks", 32'(k - first_fs), 32'd196);
                first_fs = k;
            end
            if (s_ls) ls_run++;
            else if (ls_run > 0) begin
                cmp("S_ls_clocks", 32'(ls_run), 32'd2);
                ls_run = 0;
            end
            p_sfs = s_fs;
        end

        // Assert reset mid-frame between clock edges and check that the outputs respond at once.
        guard = 0;
        while (md.x != 300 && guard < 2000) begin
            cyc(1'b1);
            guard++;
        end
        cmp("D_pre_reset_x", 32'(d_x), 32'd300);
        #2;
        rst = 1'b1;
        #1;
        md = m_reset(td);
        ms = m_reset(ts);
        qd.push_back(m_exp(md, td));
        qs.push_back(m_exp(ms, ts));
        check_outputs();
        repeat (3) cyc(1'b1);
        rst = 1'b0;

        // Restart and run long enough for the small frame counter to wrap.
        vs_cnt = 0;
        for (int k = 1; k <= 25100; k++) begin
            cyc(1'b1);
            if (k == 1) begin
                cmp("D_restart_x", 32'(d_x), 32'd0);
                cmp("D_restart_fs", 32'(d_fs), 32'd1);
            end
            if (k <= 98 && s_vs) vs_cnt++;
            if (k == 98) cmp("S_vsync_clocks", 32'(vs_cnt), 32'd14);
            if (s_hs) cmp("S_hs_window", 32'(s_x >= 4'd10 && s_x <= 4'd11), 32'd1);
            if (k == 1 + 255 * 98) cmp("S_fc_255", 32'(s_fc), 32'd255);
            if (k == 1 + 256 * 98) cmp("S_fc_wrap", 32'(s_fc), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
